// File: rtl/spi_sync_decoder.sv
// SPI receive decoder: synchronises sck/din/cs into clk, extracts bytes in any SPI mode.
// Define SPIDEC_FRAMEERR_EN to build the aborted-partial-byte (frame_err) detector.
module spi_sync_decoder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_i,
    input  logic        sck,
    input  logic        din,
    input  logic        cs,
    input  logic        cfg_enable,
    input  logic        cfg_cpol,
    input  logic        cfg_cpha,
    input  logic        cfg_lsb_first,
    output logic [7:0]  dataout,
    output logic        data_rdy,
    output logic [15:0] byte_cnt,
    output logic        busy,
    output logic        frame_err
);

    logic [SYNC_STAGES-1:0] sck_sync_q, din_sync_q, cs_sync_q;
    logic                   sck_dly_q, cs_dly_q;
    logic [SYNC_STAGES:0]   arm_q;

    logic       busy_q, busy_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [7:0] sr_q, sr_d;
    logic [7:0] dout_q, dout_d;
    logic       rdy_q, rdy_d;
    logic [15:0] bcnt_q, bcnt_d;
    logic       cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;

    logic       sck_s, din_s, cs_s;
    logic       armed, frame_start, frame_end, sck_rise, sck_fall, sample;
    logic [7:0] shift_nxt;

    // All three pins share one depth so din stays aligned with its sck edge.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            sck_sync_q <= '0;
            din_sync_q <= '0;
            cs_sync_q  <= '1;
            sck_dly_q  <= 1'b0;
            cs_dly_q   <= 1'b1;
            arm_q      <= '0;
        end else begin
            sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck};
            din_sync_q <= {din_sync_q[SYNC_STAGES-2:0], din};
            cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], cs};
            sck_dly_q  <= sck_sync_q[SYNC_STAGES-1];
            cs_dly_q   <= cs_sync_q[SYNC_STAGES-1];
            arm_q      <= {arm_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign sck_s = sck_sync_q[SYNC_STAGES-1];
    assign din_s = din_sync_q[SYNC_STAGES-1];
    assign cs_s  = cs_sync_q[SYNC_STAGES-1];

    // The reset value of the cs chain is not a real pin level; wait until the
    // chain and its delayed copy hold sampled values before accepting a start.
    assign armed       = arm_q[SYNC_STAGES];
    assign frame_start = armed & ~busy_q & cs_dly_q & ~cs_s & cfg_enable;
    assign frame_end   = busy_q & (cs_s | ~cfg_enable);
    assign sck_rise    = sck_s & ~sck_dly_q;
    assign sck_fall    = ~sck_s & sck_dly_q;
    assign sample      = busy_q & ~frame_end & ((cpol_q == cpha_q) ? sck_rise : sck_fall);
    assign shift_nxt   = lsb_q ? {din_s, sr_q[7:1]} : {sr_q[6:0], din_s};

    always_comb begin
        busy_d   = busy_q;
        bitcnt_d = bitcnt_q;
        sr_d     = sr_q;
        dout_d   = dout_q;
        rdy_d    = 1'b0;
        bcnt_d   = bcnt_q;
        cpol_d   = cpol_q;
        cpha_d   = cpha_q;
        lsb_d    = lsb_q;
        if (frame_start) begin
            busy_d   = 1'b1;
            bitcnt_d = 3'd0;
            sr_d     = 8'h00;
            bcnt_d   = 16'h0000;
            cpol_d   = cfg_cpol;
            cpha_d   = cfg_cpha;
            lsb_d    = cfg_lsb_first;
        end else if (frame_end) begin
            busy_d   = 1'b0;
            bitcnt_d = 3'd0;
            sr_d     = 8'h00;
        end else if (sample) begin
            sr_d     = shift_nxt;
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
                dout_d = shift_nxt;
                rdy_d  = 1'b1;
                if (bcnt_q != 16'hFFFF) bcnt_d = bcnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            busy_q   <= 1'b0;
            bitcnt_q <= 3'd0;
            sr_q     <= 8'h00;
            dout_q   <= 8'h00;
            rdy_q    <= 1'b0;
            bcnt_q   <= 16'h0000;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            lsb_q    <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            bitcnt_q <= bitcnt_d;
            sr_q     <= sr_d;
            dout_q   <= dout_d;
            rdy_q    <= rdy_d;
            bcnt_q   <= bcnt_d;
            cpol_q   <= cpol_d;
            cpha_q   <= cpha_d;
            lsb_q    <= lsb_d;
        end
    end

`ifdef SPIDEC_FRAMEERR_EN
    logic ferr_q;
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) ferr_q <= 1'b0;
        else         ferr_q <= ~frame_start & frame_end & (bitcnt_q != 3'd0);
    end
    assign frame_err = ferr_q;
`else
    assign frame_err = 1'b0;
`endif

    assign dataout  = dout_q;
    assign data_rdy = rdy_q;
    assign byte_cnt = bcnt_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_spi_sync_decoder.sv
// Bench for spi_sync_decoder: a 2-stage and a 3-stage instance share the same pins;
// the reference model is "bytes sent on the wire come back out in order".
module tb_spi_sync_decoder;

    localparam int H = 5;  // sck half period in clk cycles

    logic clk = 1'b0;
    logic reset_i, sck, din, cs, cfg_enable, cfg_cpol, cfg_cpha, cfg_lsb_first;
    logic [7:0] dataout, dataout3;
    logic data_rdy, data_rdy3, busy, busy3, frame_err, frame_err3;
    logic [15:0] byte_cnt, byte_cnt3;

    int checks = 0, errs = 0;
    logic [7:0] rx_q[$], rx3_q[$], exp_q[$];
    int fe_cnt = 0, dbl_cnt = 0;
    logic rdy_prev = 1'b0, rdy3_prev = 1'b0, fe_prev = 1'b0;
    time t_rdy = 0, t_rdy3 = 0, t_samp = 0;
    bit cur_cpol, cur_cpha, cur_lsb;
`ifdef SPIDEC_FRAMEERR_EN
    localparam int FE_EXP = 1;
`else
    localparam int FE_EXP = 0;
`endif

    always #5 clk = ~clk;

    spi_sync_decoder dut (
        .clk(clk), .reset_i(reset_i), .sck(sck), .din(din), .cs(cs),
        .cfg_enable(cfg_enable), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha),
        .cfg_lsb_first(cfg_lsb_first), .dataout(dataout), .data_rdy(data_rdy),
        .byte_cnt(byte_cnt), .busy(busy), .frame_err(frame_err));

    spi_sync_decoder #(.SYNC_STAGES(3)) dut3 (
        .clk(clk), .reset_i(reset_i), .sck(sck), .din(din), .cs(cs),
        .cfg_enable(cfg_enable), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha),
        .cfg_lsb_first(cfg_lsb_first), .dataout(dataout3), .data_rdy(data_rdy3),
        .byte_cnt(byte_cnt3), .busy(busy3), .frame_err(frame_err3));

    // Observe strobes away from the active edge.
    always @(negedge clk) begin
        if (data_rdy) begin
            rx_q.push_back(dataout);
            t_rdy = $time;
            if (rdy_prev) dbl_cnt++;
        end
        if (data_rdy3) begin
            rx3_q.push_back(dataout3);
            t_rdy3 = $time;
            if (rdy3_prev) dbl_cnt++;
        end
        if (frame_err) begin
            fe_cnt++;
            if (fe_prev) dbl_cnt++;
        end
        rdy_prev  = data_rdy;
        rdy3_prev = data_rdy3;
        fe_prev   = frame_err;
    end

    // Pin changes happen 3 time units after a rising clk edge, i.e. asynchronously-ish.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic frame_begin(input bit cpol, input bit cpha, input bit lsb);
        cur_cpol = cpol; cur_cpha = cpha; cur_lsb = lsb;
        cfg_cpol = cpol; cfg_cpha = cpha; cfg_lsb_first = lsb;
        sck = cpol; din = 1'b0;
        tick(6);
        cs = 1'b0;
        tick(6);
    endtask

    task automatic frame_end();
        tick(H);
        cs = 1'b1;
        tick(8);
    endtask

    // Wire bits [from..to] of byte b in transmission order for the current mode.
    task automatic send_bits(input logic [7:0] b, input int from, input int to);
        for (int i = from; i <= to; i++) begin
            logic v;
            v = cur_lsb ? b[i] : b[7-i];
            if (!cur_cpha) begin
                din = v; tick(H);
                sck = ~cur_cpol; t_samp = $time; tick(H);
                sck = cur_cpol;
            end else begin
                sck = ~cur_cpol; din = v; tick(H);
                sck = cur_cpol; t_samp = $time; tick(H);
            end
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b1; cs = 1'b1; sck = 1'b0; din = 1'b0;
        cfg_enable = 1'b1; cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_lsb_first = 1'b0;
        tick(3);
        checks++; if (dataout !== 8'h00) begin errs++; $display("FAIL reset_dataout got %h want 00", dataout); end
        checks++; if (data_rdy !== 1'b0) begin errs++; $display("FAIL reset_rdy got %b want 0", data_rdy); end
        checks++; if (byte_cnt !== 16'h0) begin errs++; $display("FAIL reset_bytecnt got %h want 0", byte_cnt); end
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (frame_err !== 1'b0) begin errs++; $display("FAIL reset_frameerr got %b want 0", frame_err); end
        reset_i = 1'b0;
        tick(8);
    endtask

    task automatic test_mode0_two_bytes();
        int b0;
        b0 = rx_q.size();
        frame_begin(0, 0, 0);
        checks++; if (busy !== 1'b1) begin errs++; $display("FAIL m0_busy_hi got %b want 1", busy); end
        send_bits(8'hA5, 0, 7);
        send_bits(8'h3C, 0, 7);
        frame_end();
        checks++;
        if (rx_q.size() != b0 + 2) begin
            errs++; $display("FAIL m0_count got %0d want 2", rx_q.size() - b0);
        end else if (rx_q[b0] !== 8'hA5 || rx_q[b0+1] !== 8'h3C) begin
            errs++; $display("FAIL m0_data got %h %h want a5 3c", rx_q[b0], rx_q[b0+1]);
        end
        checks++; if (byte_cnt !== 16'd2) begin errs++; $display("FAIL m0_bytecnt got %0d want 2", byte_cnt); end
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL m0_busy_lo got %b want 0", busy); end
        checks++; if (dataout !== 8'h3C) begin errs++; $display("FAIL m0_hold got %h want 3c", dataout); end
    endtask

    task automatic test_modes_lsb();
        bit [1:0] modes[3];
        modes[0] = 2'b11; modes[1] = 2'b01; modes[2] = 2'b10;
        for (int m = 0; m < 3; m++) begin
            int b0;
            b0 = rx_q.size();
            frame_begin(modes[m][1], modes[m][0], 1);
            send_bits(8'h01, 0, 7);
            frame_end();
            checks++;
            if (rx_q.size() != b0 + 1 || rx_q[b0] !== 8'h01) begin
                errs++; $display("FAIL lsb_mode%0d got n=%0d d=%h want n=1 d=01", modes[m], rx_q.size() - b0, dataout);
            end
        end
    endtask

    task automatic test_partial_byte();
        int b0, f0;
        b0 = rx_q.size(); f0 = fe_cnt;
        frame_begin(0, 0, 0);
        send_bits(8'h5A, 0, 7);
        send_bits(8'h77, 0, 4);
        frame_end();
        checks++; if (rx_q.size() != b0 + 1) begin errs++; $display("FAIL partial_count got %0d want 1", rx_q.size() - b0); end
        checks++; if (byte_cnt !== 16'd1) begin errs++; $display("FAIL partial_bytecnt got %0d want 1", byte_cnt); end
        checks++; if (dataout !== 8'h5A) begin errs++; $display("FAIL partial_hold got %h want 5a", dataout); end
        checks++; if (fe_cnt - f0 != FE_EXP) begin errs++; $display("FAIL partial_frameerr got %0d want %0d", fe_cnt - f0, FE_EXP); end
    endtask

    task automatic test_cfg_latch();
        int b0;
        b0 = rx_q.size();
        frame_begin(0, 0, 0);
        send_bits(8'h55, 0, 2);
        cfg_cpol = 1'b1;
        send_bits(8'h55, 3, 7);
        frame_end();
        frame_begin(1, 0, 0);
        send_bits(8'h96, 0, 7);
        frame_end();
        checks++;
        if (rx_q.size() != b0 + 2) begin
            errs++; $display("FAIL cfg_latch_count got %0d want 2", rx_q.size() - b0);
        end else if (rx_q[b0] !== 8'h55 || rx_q[b0+1] !== 8'h96) begin
            errs++; $display("FAIL cfg_latch_data got %h %h want 55 96", rx_q[b0], rx_q[b0+1]);
        end
    endtask

    task automatic test_enable_drop();
        int b0, f0;
        b0 = rx_q.size(); f0 = fe_cnt;
        frame_begin(0, 0, 0);
        send_bits(8'hE7, 0, 2);
        cfg_enable = 1'b0;
        tick(6);
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL endrop_busy got %b want 0", busy); end
        send_bits(8'hE7, 3, 7);
        frame_end();
        cfg_enable = 1'b1;
        tick(4);
        checks++; if (rx_q.size() != b0) begin errs++; $display("FAIL endrop_count got %0d want 0", rx_q.size() - b0); end
        checks++; if (fe_cnt - f0 != FE_EXP) begin errs++; $display("FAIL endrop_frameerr got %0d want %0d", fe_cnt - f0, FE_EXP); end
    endtask

    task automatic test_reset_midframe();
        int b0, f0;
        b0 = rx_q.size(); f0 = fe_cnt;
        frame_begin(0, 0, 0);
        send_bits(8'hF0, 0, 3);
        reset_i = 1'b1;
        tick(2);
        reset_i = 1'b0;
        tick(1);
        checks++;
        if (dataout !== 8'h00 || byte_cnt !== 16'h0 || busy !== 1'b0 || data_rdy !== 1'b0) begin
            errs++; $display("FAIL rstmid_outputs got d=%h n=%0d b=%b r=%b want all 0", dataout, byte_cnt, busy, data_rdy);
        end
        send_bits(8'hF0, 4, 7);
        tick(6);
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL rstmid_nostart got %b want 0", busy); end
        checks++;
        if (rx_q.size() != b0 || fe_cnt != f0) begin
            errs++; $display("FAIL rstmid_strobes got rdy=%0d fe=%0d want 0 0", rx_q.size() - b0, fe_cnt - f0);
        end
        cs = 1'b1;
        tick(6);
        frame_begin(0, 0, 0);
        send_bits(8'hC3, 0, 7);
        frame_end();
        checks++;
        if (rx_q.size() != b0 + 1 || dataout !== 8'hC3) begin
            errs++; $display("FAIL rstmid_c3 got n=%0d d=%h want n=1 d=c3", rx_q.size() - b0, dataout);
        end
    endtask

    task automatic test_latency();
        time d2, d3;
        frame_begin(0, 0, 0);
        send_bits(8'hFF, 0, 7);
        frame_end();
        d2 = t_rdy - t_samp;
        d3 = t_rdy3 - t_samp;
        // Sample edges land 3 units after a rising clk; strobes are seen at the next falling edge.
        checks++; if (d2 < 2 || (d2 - 2) / 10 != 3) begin errs++; $display("FAIL latency_s2 got %0t want 3 edges", d2); end
        checks++; if (d3 < 2 || (d3 - 2) / 10 != 4) begin errs++; $display("FAIL latency_s3 got %0t want 4 edges", d3); end
        checks++; if (dataout3 !== 8'hFF) begin errs++; $display("FAIL latency_data got %h want ff", dataout3); end
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 16; f++) begin
            int b0, b3, nb;
            bit [1:0] md;
            bit lsb;
            b0 = rx_q.size(); b3 = rx3_q.size();
            md = 2'($urandom_range(0, 3));
            lsb = 1'($urandom_range(0, 1));
            nb = $urandom_range(1, 3);
            exp_q.delete();
            frame_begin(md[1], md[0], lsb);
            for (int k = 0; k < nb; k++) begin
                logic [7:0] v;
                v = 8'($urandom);
                exp_q.push_back(v);
                send_bits(v, 0, 7);
            end
            frame_end();
            checks++;
            if (rx_q.size() != b0 + nb || byte_cnt !== 16'(nb)) begin
                errs++; $display("FAIL rand%0d_count got %0d/%0d want %0d", f, rx_q.size() - b0, byte_cnt, nb);
            end else begin
                for (int k = 0; k < nb; k++)
                    if (rx_q[b0+k] !== exp_q[k] || rx3_q.size() != b3 + nb || rx3_q[b3+k] !== exp_q[k]) begin
                        errs++; $display("FAIL rand%0d_byte%0d got %h want %h (mode %0d lsb %0d)", f, k, rx_q[b0+k], exp_q[k], md, lsb);
                    end
            end
        end
        checks++; if (dbl_cnt != 0) begin errs++; $display("FAIL strobe_width got %0d long pulses want 0", dbl_cnt); end
    endtask

    initial begin
        test_reset();
        test_mode0_two_bytes();
        test_modes_lsb();
        test_partial_byte();
        test_cfg_latch();
        test_enable_drop();
        test_reset_midframe();
        test_latency();
        test_random_frames();
        $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
        $finish;
    end

endmodule
